// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues one imem request at a time, holds the returned
// word for decode and generates next_pc (hold, +4 or redirect).
module ifetch_unit #(
   parameter int unsigned RESET_HOLD = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic [31:0] next_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        inst_fault,
   output logic [2:0]  dbg_state
);

   // Handshakes: a transfer occurs on a cycle where valid and ready are both high;
   // once raised, valid and its payload hold until that cycle, the single exception
   // being a redirect, which may retarget a request that has not been accepted yet.

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

   state_t      state, state_nx;
   logic [3:0]  hold_cnt, hold_cnt_nx;
   logic [31:0] inst_data_nx, inst_pc_nx;
   logic        inst_fault_nx;
   logic        misaligned;

   assign misaligned    = (pc[1:0] != 2'b00);
   assign imem_req_addr = pc;
   assign inst_valid    = (state == HOLD);
   assign dbg_state     = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         hold_cnt   <= 4'd0;
         inst_data  <= 32'd0;
         inst_pc    <= 32'd0;
         inst_fault <= 1'b0;
      end else begin
         state      <= state_nx;
         hold_cnt   <= hold_cnt_nx;
         inst_data  <= inst_data_nx;
         inst_pc    <= inst_pc_nx;
         inst_fault <= inst_fault_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      hold_cnt_nx    = hold_cnt;
      inst_data_nx   = inst_data;
      inst_pc_nx     = inst_pc;
      inst_fault_nx  = inst_fault;
      imem_req_valid = 1'b0;

      if (redirect_valid)
         next_pc = redirect_target;
      else if (state == HOLD && inst_ready)
         next_pc = inst_pc + 32'd4;
      else
         next_pc = pc;

      case (state)
         // A redirect here only moves next_pc; the hold count always completes.
         IDLE: begin
            if (hold_cnt == HOLD_LAST)
               state_nx = REQ;
            else
               hold_cnt_nx = hold_cnt + 4'd1;
         end
         REQ: begin
            imem_req_valid = !misaligned;
            if (redirect_valid) begin
               state_nx = (imem_req_ready && !misaligned) ? DRAIN : REQ;
            end else if (misaligned) begin
               state_nx      = HOLD;
               inst_data_nx  = 32'd0;
               inst_pc_nx    = pc;
               inst_fault_nx = 1'b1;
            end else if (imem_req_ready) begin
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               state_nx = imem_rsp_valid ? REQ : DRAIN;
            end else if (imem_rsp_valid) begin
               state_nx      = HOLD;
               inst_data_nx  = imem_rsp_err ? 32'd0 : imem_rsp_data;
               inst_pc_nx    = pc;
               inst_fault_nx = imem_rsp_err;
            end
         end
         HOLD: begin
            if (redirect_valid || inst_ready)
               state_nx = REQ;
         end
         // The stale response ends the drain even if another redirect coincides.
         DRAIN: begin
            if (imem_rsp_valid)
               state_nx = REQ;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: PC register and memory models around the DUT, an
// architectural next-PC model, directed scenarios, then randomized traffic.
module tb_ifetch_unit;

   localparam int unsigned HOLD_CYC = 3;

   logic        clk, reset;
   logic [31:0] pc, next_pc;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_data, inst_pc;
   logic        inst_fault;
   logic [2:0]  dbg_state;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [31:0] exp_pc;
   logic        presented;
   logic [31:0] exp_q[$];
   int          pres_cyc[$];
   int          rsp_cd = -1;
   logic [31:0] rsp_addr;
   int          next_lat = 1;
   logic        last_req, last_accept, last_present;
   logic [31:0] last_addr, pres_pc, pres_data;
   logic        pres_fault;
   int          pres_count = 0;

   ifetch_unit #(.RESET_HOLD(HOLD_CYC)) dut (
      .clk(clk), .reset(reset), .pc(pc), .next_pc(next_pc),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
      .inst_pc(inst_pc), .inst_fault(inst_fault), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset / PC register ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) pc <= 32'd0;
      else       pc <= next_pc;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // ---------------- memory contents and reference rules ----------------
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic err_at(input logic [31:0] a);
      return (a[7:0] == 8'h20) || (a[7:0] == 8'hB4);
   endfunction

   function automatic logic exp_fault(input logic [31:0] a);
      return (a[1:0] != 2'b00) || err_at(a);
   endfunction

   function automatic logic [31:0] exp_data(input logic [31:0] a);
      return exp_fault(a) ? 32'd0 : mem_word(a);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample/check at negedge, advance, then drive memory response.
   task automatic cycle();
      logic [31:0] en;
      @(negedge clk);
      last_req     = imem_req_valid;
      last_addr    = imem_req_addr;
      last_accept  = 1'b0;
      last_present = 1'b0;
      if (reset) begin
         exp_pc    = 32'd0;
         presented = 1'b0;
      end else begin
         if (imem_req_valid) begin
            check("req_addr", imem_req_addr, exp_pc);
            check("req_aligned", {30'd0, exp_pc[1:0]}, 32'd0);
         end
         if (imem_req_valid && imem_req_ready) begin
            check("one_outstanding", (rsp_cd >= 0) ? 32'd1 : 32'd0, 32'd0);
            rsp_addr    = imem_req_addr;
            rsp_cd      = next_lat;
            last_accept = 1'b1;
         end
         if (inst_valid) begin
            check("hold_no_req", 32'(imem_req_valid), 32'd0);
            check("inst_pc", inst_pc, exp_pc);
            check("inst_fault", 32'(inst_fault), 32'(exp_fault(exp_pc)));
            check("inst_data", inst_data, exp_data(exp_pc));
            if (!presented) begin
               presented    = 1'b1;
               last_present = 1'b1;
               pres_pc      = inst_pc;
               pres_data    = inst_data;
               pres_fault   = inst_fault;
               pres_count++;
               pres_cyc.push_back(cyc);
               if (exp_q.size() > 0) check("seq_pc", inst_pc, exp_q.pop_front());
            end
         end
         en = redirect_valid ? redirect_target :
              (inst_valid && inst_ready) ? exp_pc + 32'd4 : exp_pc;
         check("next_pc", next_pc, en);
         if (redirect_valid || (inst_valid && inst_ready)) presented = 1'b0;
         exp_pc = en;
      end
      @(posedge clk);
      #1;
      cyc++;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      imem_rsp_err   = 1'b0;
      if (rsp_cd > 0) begin
         rsp_cd--;
         if (rsp_cd == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(rsp_addr);
            imem_rsp_err   = err_at(rsp_addr);
            rsp_cd         = -1;
         end
      end
   endtask

   task automatic wait_present(input int max, input string tag);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (!last_present && n < max);
      check({tag, "_timeout"}, 32'(last_present), 32'd1);
   endtask

   task automatic wait_accept(input int max, input string tag);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (!last_accept && n < max);
      check({tag, "_timeout"}, 32'(last_accept), 32'd1);
   endtask

   // Cycles from now until a request is seen (the request cycle included).
   task automatic cycles_to_req(output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!last_req && n < 30);
   endtask

   // ---------------- directed steps, then random traffic ----------------
   initial begin
      int n, reqs, first_req, base;
      logic [31:0] t;
      reset = 1'b1;
      redirect_valid = 1'b0;  redirect_target = 32'd0;
      imem_req_ready = 1'b0;  inst_ready = 1'b0;
      imem_rsp_valid = 1'b0;  imem_rsp_data = 32'd0;  imem_rsp_err = 1'b0;
      exp_pc = 32'd0;  presented = 1'b0;

      // reset values
      @(negedge clk);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_inst_fault", 32'(inst_fault), 32'd0);
      check("rst_state", {29'd0, dbg_state}, 32'd0);
      check("rst_next_pc", next_pc, 32'd0);
      redirect_valid = 1'b1;  redirect_target = 32'h40;
      #1;
      check("rst_next_pc_redirect", next_pc, 32'h40);
      redirect_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // sequential fetch, zero-wait memory, decode always ready
      imem_req_ready = 1'b1;  inst_ready = 1'b1;  next_lat = 1;
      exp_q.push_back(32'h0);  exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);  exp_q.push_back(32'hC);
      cycles_to_req(n);
      check("idle_cycles", n - 1, HOLD_CYC);
      first_req = cyc - 1;
      pres_cyc.delete();
      for (int k = 0; k < 4; k++) wait_present(10, "seq");
      check("seq_first_latency", pres_cyc[0], first_req + 2);
      for (int k = 1; k < 4; k++) check("seq_spacing", pres_cyc[k] - pres_cyc[k-1], 3);
      check("seq_queue_empty", exp_q.size(), 0);

      // backpressure in HOLD
      inst_ready = 1'b0;
      wait_present(10, "bp");
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("bp_no_req", 32'(last_req), 32'd0);
      end
      inst_ready = 1'b1;
      #1;
      check("bp_release_next_pc", next_pc, pres_pc + 32'd4);
      cycle();

      // redirect in WAIT with a slow response: drain, then fetch the target
      next_lat = 4;
      wait_accept(10, "drain_accept");
      next_lat = 1;
      redirect_valid = 1'b1;  redirect_target = 32'h100;
      cycle();
      redirect_valid = 1'b0;
      cycles_to_req(n);
      check("drain_req_delay", n, 4);
      check("drain_req_addr", last_addr, 32'h100);
      inst_ready = 1'b0;
      wait_present(10, "drain_inst");
      check("drain_inst_pc", pres_pc, 32'h100);

      // misaligned redirect from HOLD
      redirect_valid = 1'b1;  redirect_target = 32'h102;
      cycle();
      redirect_valid = 1'b0;
      n = 0;  reqs = 0;
      do begin
         cycle();
         n++;
         if (last_req) reqs++;
      end while (!last_present && n < 10);
      check("mis_no_req", reqs, 0);
      check("mis_latency", n, 2);
      check("mis_pc", pres_pc, 32'h102);
      check("mis_fault", 32'(pres_fault), 32'd1);
      check("mis_data", pres_data, 32'd0);

      // bus error at 0x20 (redirect wins over a simultaneous consume)
      inst_ready = 1'b1;
      redirect_valid = 1'b1;  redirect_target = 32'h18;
      cycle();
      redirect_valid = 1'b0;
      for (int k = 0; k < 3; k++) wait_present(10, "berr");
      check("berr_pc", pres_pc, 32'h20);
      check("berr_fault", 32'(pres_fault), 32'd1);
      check("berr_data", pres_data, 32'd0);

      // PC wrap
      inst_ready = 1'b0;
      redirect_valid = 1'b1;  redirect_target = 32'hFFFF_FFFC;
      cycle();
      redirect_valid = 1'b0;
      wait_present(15, "wrap");
      check("wrap_pc", pres_pc, 32'hFFFF_FFFC);
      inst_ready = 1'b1;
      #1;
      check("wrap_next_pc", next_pc, 32'd0);
      cycle();
      wait_present(10, "wrap0");
      check("wrap0_pc", pres_pc, 32'd0);

      // reset mid-WAIT with a late response
      next_lat = 5;
      wait_accept(10, "rst_accept");
      next_lat = 1;
      reset = 1'b1;
      #1;
      check("rst_mid_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_mid_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_mid_inst_data", inst_data, 32'd0);
      check("rst_mid_inst_pc", inst_pc, 32'd0);
      check("rst_mid_inst_fault", 32'(inst_fault), 32'd0);
      check("rst_mid_next_pc", next_pc, 32'd0);
      cycle();
      cycle();
      reset = 1'b0;
      cycles_to_req(n);
      check("rst_mid_idle_cycles", n - 1, HOLD_CYC);
      check("rst_mid_req_addr", last_addr, 32'd0);
      wait_present(10, "rst_mid_inst");
      check("rst_mid_first_pc", pres_pc, 32'd0);

      // randomized traffic against the architectural model
      base = pres_count;
      for (int k = 0; k < 800; k++) begin
         imem_req_ready = ($urandom_range(0, 3) != 0);
         inst_ready     = ($urandom_range(0, 4) < 3);
         next_lat       = $urandom_range(1, 3);
         if ($urandom_range(0, 19) == 0) begin
            t = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF0;
            redirect_valid  = 1'b1;
            redirect_target = t;
         end else begin
            redirect_valid = 1'b0;
         end
         cycle();
      end
      redirect_valid = 1'b0;
      check("random_progress", (pres_count - base > 40) ? 32'd1 : 32'd0, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
